// File: rtl/grid_env_step.sv
// Grid-world environment responder: applies an agent action, returns next state, reward and done.
// Optional obstacle cell enabled by defining GRID_ENV_OBSTACLE_EN.
module grid_env_step #(
  parameter int GRID_WIDTH    = 8,
  parameter int GRID_HEIGHT   = 8,
  parameter int STATE_LENGTH  = 6,
  parameter int START_STATE   = 0,
  parameter int GOAL_STATE    = 63,
  parameter int REWARD_LENGTH = 8,
  parameter int REWARD_GOAL   = 100,
  parameter int REWARD_STEP   = -1,
  parameter int REWARD_BUMP   = -5,
  parameter int STEP_LENGTH   = 8,
  parameter int MAX_STEPS     = 255
`ifdef GRID_ENV_OBSTACLE_EN
  ,
  parameter int OBSTACLE_STATE = 27
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     action_valid,
  input  logic [1:0]               action,
  output logic                     action_ready,
  output logic [STATE_LENGTH-1:0]  cur_state,
  output logic                     step_valid,
  input  logic                     step_ready,
  output logic [STATE_LENGTH-1:0]  next_state,
  output logic [REWARD_LENGTH-1:0] reward,
  output logic                     done,
  output logic [15:0]              episode_count
);

  localparam int unsigned ROW_W = (GRID_HEIGHT > 1) ? $clog2(GRID_HEIGHT) : 1;
  localparam int unsigned COL_W = (GRID_WIDTH > 1) ? $clog2(GRID_WIDTH) : 1;
  localparam logic [ROW_W-1:0] START_ROW = ROW_W'(START_STATE / GRID_WIDTH);
  localparam logic [COL_W-1:0] START_COL = COL_W'(START_STATE % GRID_WIDTH);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(GRID_HEIGHT - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(GRID_WIDTH - 1);
  localparam logic [STEP_LENGTH-1:0]   MAX_CNT = STEP_LENGTH'(MAX_STEPS);
  localparam logic [REWARD_LENGTH-1:0] RW_GOAL = REWARD_LENGTH'(REWARD_GOAL);
  localparam logic [REWARD_LENGTH-1:0] RW_STEP = REWARD_LENGTH'(REWARD_STEP);
  localparam logic [REWARD_LENGTH-1:0] RW_BUMP = REWARD_LENGTH'(REWARD_BUMP);

  typedef enum logic [1:0] {IDLE, MOVE, RESPOND} state_t;

  state_t                   state, state_n;
  logic [ROW_W-1:0]         row, nrow, cand_row, land_row;
  logic [COL_W-1:0]         col, ncol, cand_col, land_col;
  logic [1:0]               act_q;
  logic [STEP_LENGTH-1:0]   step_cnt, cnt_inc;
  logic [STATE_LENGTH-1:0]  cand_state, land_state;
  logic                     blocked, is_goal, done_c;
  logic [REWARD_LENGTH-1:0] reward_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and move evaluation
  always_comb begin
    state_n  = state;
    cand_row = row;
    cand_col = col;
    blocked  = 1'b0;
    case (act_q)
      2'd0:    if (row == '0)      blocked = 1'b1; else cand_row = row - ROW_W'(1);
      2'd1:    if (row == LAST_ROW) blocked = 1'b1; else cand_row = row + ROW_W'(1);
      2'd2:    if (col == '0)      blocked = 1'b1; else cand_col = col - COL_W'(1);
      default: if (col == LAST_COL) blocked = 1'b1; else cand_col = col + COL_W'(1);
    endcase
    cand_state = STATE_LENGTH'(int'(cand_row) * GRID_WIDTH + int'(cand_col));
`ifdef GRID_ENV_OBSTACLE_EN
    if ((OBSTACLE_STATE != GOAL_STATE) && (OBSTACLE_STATE != START_STATE) &&
        (cand_state == STATE_LENGTH'(OBSTACLE_STATE)))
      blocked = 1'b1;
`endif
    land_row   = blocked ? row : cand_row;
    land_col   = blocked ? col : cand_col;
    land_state = blocked ? cur_state : cand_state;
    is_goal    = !blocked && (land_state == STATE_LENGTH'(GOAL_STATE));
    reward_c   = blocked ? RW_BUMP : (is_goal ? RW_GOAL : RW_STEP);
    cnt_inc    = (step_cnt >= MAX_CNT) ? MAX_CNT : step_cnt + STEP_LENGTH'(1);
    done_c     = is_goal || (cnt_inc == MAX_CNT);
    case (state)
      IDLE:    if (action_valid) state_n = MOVE;
      MOVE:    state_n = RESPOND;
      RESPOND: if (step_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row           <= START_ROW;
      col           <= START_COL;
      nrow          <= '0;
      ncol          <= '0;
      act_q         <= '0;
      step_cnt      <= '0;
      cur_state     <= STATE_LENGTH'(START_STATE);
      next_state    <= '0;
      reward        <= '0;
      done          <= 1'b0;
      episode_count <= '0;
      action_ready  <= 1'b1;
      step_valid    <= 1'b0;
    end else begin
      action_ready <= (state_n == IDLE);
      step_valid   <= (state_n == RESPOND);
      case (state)
        IDLE: if (action_valid) act_q <= action;
        MOVE: begin
          nrow       <= land_row;
          ncol       <= land_col;
          step_cnt   <= cnt_inc;
          next_state <= land_state;
          reward     <= reward_c;
          done       <= done_c;
        end
        RESPOND: if (step_ready) begin
          if (done) begin
            row           <= START_ROW;
            col           <= START_COL;
            cur_state     <= STATE_LENGTH'(START_STATE);
            step_cnt      <= '0;
            episode_count <= episode_count + 16'd1;
          end else begin
            row       <= nrow;
            col       <= ncol;
            cur_state <= next_state;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/grid_env_step.md
Name: grid_env_step

Overview:
- Environment-side responder for the epsilon-greedy action selector. It consumes the 2-bit action the agent picks, moves the agent on a GRID_WIDTH x GRID_HEIGHT grid world, and returns next state, reward and episode-done to the Q-update path.
- Sits between the action-selection stage and the Q-table update stage.
- Uses a valid/ready handshake on both sides.

Parameters:
- GRID_WIDTH, 8, number of columns.
- GRID_HEIGHT, 8, number of rows.
- STATE_LENGTH, 6, state index width; must satisfy 2^STATE_LENGTH >= GRID_WIDTH*GRID_HEIGHT.
- START_STATE, 0, state index the agent occupies after reset and after every episode end.
- GOAL_STATE, 63, terminal state index.
- REWARD_LENGTH, 8, signed two's-complement reward width.
- REWARD_GOAL, 100, reward when entering GOAL_STATE.
- REWARD_STEP, -1, reward for a legal non-goal move.
- REWARD_BUMP, -5, reward when the move is blocked by the grid edge.
- STEP_LENGTH, 8, episode step counter width.
- MAX_STEPS, 255, step count at which the episode times out.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- action_valid  in  1  action presented.
- action  in  2  action code: 0=up (row-1), 1=down (row+1), 2=left (col-1), 3=right (col+1).
- action_ready  out  1  block can accept an action.
- cur_state  out  STATE_LENGTH  state the agent currently occupies (row*GRID_WIDTH+col).
- step_valid  out  1  step result available.
- step_ready  in  1  consumer accepts the step result.
- next_state  out  STATE_LENGTH  resulting state of the step.
- reward  out  REWARD_LENGTH  signed reward of the step.
- done  out  1  step ended the episode (goal reached or timeout).
- episode_count  out  16  completed episodes, wraps at 65535->0.

Behaviour:
- Reset values (async on rst): FSM=IDLE; row/col = START_STATE coordinates; cur_state=START_STATE; step counter=0; action_ready=1; step_valid=0; next_state=0; reward=0; done=0; episode_count=0.
- FSM IDLE:
  - action_ready=1, step_valid=0.
  - On action_valid&&action_ready, latch the action and go to MOVE.
- FSM MOVE (1 cycle):
  - action_ready=0.
  - Compute the target row/col.
  - A move off any edge (row 0 up, row GRID_HEIGHT-1 down, col 0 left, col GRID_WIDTH-1 right) is blocked: position is unchanged, reward=REWARD_BUMP.
  - Otherwise reward=REWARD_STEP, or REWARD_GOAL if the target equals GOAL_STATE (goal takes priority).
  - Increment the step counter; it saturates at MAX_STEPS.
  - done=1 if the target is GOAL_STATE or the incremented count equals MAX_STEPS.
  - Register next_state/reward/done, then go to RESPOND.
- FSM RESPOND:
  - step_valid=1; next_state/reward/done are held stable until step_ready.
  - On step_valid&&step_ready:
    - cur_state<=next_state, or START_STATE if done.
    - If done: step counter<=0 and episode_count<=episode_count+1.
    - Return to IDLE.
- Latency: accept edge -> step_valid high 2 cycles later. Minimum throughput is one step per 3 cycles. step_ready held high gives IDLE on the cycle after the response.
- action is ignored outside IDLE; action_valid may stay high without effect.
- cur_state changes only on the response handshake, so it always reflects the state that the selector's action applies to.
- next_state reports the actual landing cell even when done=1. The restart to START_STATE is visible only on cur_state.
- Arithmetic: reward parameters are sign-extended/truncated to REWARD_LENGTH. Row/col use widths of clog2(dim), at least 1.
- rst asserted mid-step (MOVE or RESPOND) aborts the step; nothing is retained and all outputs return to reset values.

Optional Feature:
- Macro: GRID_ENV_OBSTACLE_EN.
- Defined:
  - Adds parameter OBSTACLE_STATE (default 27).
  - A move whose target equals OBSTACLE_STATE is blocked exactly like an edge bump: position unchanged, reward=REWARD_BUMP, step counts.
  - If OBSTACLE_STATE equals GOAL_STATE or START_STATE, the obstacle is disabled.
- Undefined: no obstacle logic or parameter; every cell inside the grid is reachable.

Test Plan:
- Reset, then action=3 at state 0 with step_ready=1 -> step_valid 2 cycles after accept, next_state=1, reward=-1 (8'hFF), done=0; cur_state=1 after handshake.
- At state 0, action=0 -> next_state=0, reward=-5 (8'hFB); at state 7, action=3 -> next_state=7, reward=-5.
- Start at 55, action=1 -> next_state=63, reward=100, done=1; cur_state=0, episode_count=1, step counter cleared.
- Set MAX_STEPS=4 and issue 4 left moves from state 0 -> 4th response has done=1, reward=-5, next_state=0; episode_count increments.
- Hold step_ready=0 for 5 cycles in RESPOND while toggling action/action_valid -> outputs stable, action_ready=0, no second step; the step completes when step_ready=1.
- With GRID_ENV_OBSTACLE_EN, OBSTACLE_STATE=27, at state 26 action=3 -> next_state=26, reward=-5. Without the macro, the same stimulus gives next_state=27, reward=-1.
